// File: rtl/lvds_tx_frame_gen.sv
// lvds_tx_frame_gen
// Parallel 10-bit word source for the LVDS serializer. After reset or a
// retrain request it sends a run of training words so the receive-side
// bit-slip aligner can lock. On request it then sends framed test packets:
// header, incrementing payload, and checksum, followed by an idle gap.
// The payload bytes are (seq + i) mod 256, which is the sequence the
// receive-side checker expects.
//
// Every output is a register. At each edge the block picks the next state
// and loads the word for that state. As a result, r_state always names the
// kind of word currently on tx_word.

module lvds_tx_frame_gen #(
  parameter int          TRAIN_WORDS = 256,
  parameter int          PAYLOAD_LEN = 125,
  parameter int          GAP_WORDS   = 16,
  parameter logic [9:0]  TRAIN_WORD  = 10'h3E0,
  parameter logic [9:0]  IDLE_WORD   = 10'h0F8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        retrain,
  output logic [9:0]  tx_word,
  output logic        train_done,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int TCW = $clog2(TRAIN_WORDS + 1);

  typedef enum logic [2:0] {
    S_TRAIN,
    S_IDLE,
    S_HDR,
    S_PAY,
    S_CSUM,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [TCW-1:0]  r_train_cnt;   // training words already emitted
  logic [7:0]      r_pay_cnt;     // payload words already emitted
  logic [7:0]      r_gap_cnt;     // gap words already emitted
  logic [7:0]      r_seq;         // sequence number of the current/next frame
  logic [7:0]      r_byte;        // last payload byte emitted
  logic [7:0]      r_sum;         // running checksum of this frame's payload
  logic [9:0]      r_tx_word;
  logic            r_train_done;
  logic            r_busy;
  logic [15:0]     r_frame_cnt;

  logic [7:0]      w_next_byte;
  logic            w_train_last;
  logic            w_pay_last;
  logic            w_gap_last;

  assign w_next_byte  = r_byte + 8'd1;
  assign w_train_last = (r_train_cnt == TCW'(TRAIN_WORDS));
  assign w_pay_last   = (r_pay_cnt == 8'(PAYLOAD_LEN));
  assign w_gap_last   = (r_gap_cnt == 8'(GAP_WORDS));

  // Frame sequencer: choose the next state and load its output word.
  // NOTE: every sequential assignment here is non-blocking. Each right-hand
  // side therefore sees the value from before the edge, as the hardware does.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= S_TRAIN;
      r_train_cnt  <= '0;
      r_pay_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_seq        <= '0;
      r_byte       <= '0;
      r_sum        <= '0;
      r_tx_word    <= '0;
      r_train_done <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
    end else if (retrain) begin
      // The training word loaded here is already the first one of the new
      // run, so the count starts at one.
      r_state      <= S_TRAIN;
      r_train_cnt  <= TCW'(1);
      r_pay_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_seq        <= '0;
      r_byte       <= '0;
      r_sum        <= '0;
      r_tx_word    <= TRAIN_WORD;
      r_train_done <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      case (r_state)
        S_TRAIN: begin
          if (w_train_last) begin
            r_state      <= S_IDLE;
            r_tx_word    <= IDLE_WORD;
            r_train_done <= 1'b1;
          end else begin
            r_train_cnt  <= r_train_cnt + TCW'(1);
            r_tx_word    <= TRAIN_WORD;
          end
        end

        S_IDLE: begin
          if (start) begin
            r_state   <= S_HDR;
            r_tx_word <= {2'b10, r_seq};
            r_busy    <= 1'b1;
          end else begin
            r_tx_word <= IDLE_WORD;
          end
        end

        S_HDR: begin
          // First payload byte equals seq, and it seeds the checksum.
          r_state   <= S_PAY;
          r_byte    <= r_seq;
          r_sum     <= r_seq;
          r_pay_cnt <= 8'd1;
          r_tx_word <= {2'b01, r_seq};
        end

        S_PAY: begin
          if (w_pay_last) begin
            r_state   <= S_CSUM;
            r_tx_word <= {2'b11, r_sum};
          end else begin
            r_byte    <= w_next_byte;
            r_sum     <= r_sum + w_next_byte;
            r_pay_cnt <= r_pay_cnt + 8'd1;
            r_tx_word <= {2'b01, w_next_byte};
          end
        end

        S_CSUM: begin
          // The frame is complete once its checksum has gone out.
          r_state     <= S_GAP;
          r_seq       <= r_seq + 8'd1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_gap_cnt   <= 8'd1;
          r_tx_word   <= IDLE_WORD;
        end

        S_GAP: begin
          r_tx_word <= IDLE_WORD;
          if (w_gap_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end

        default: begin
          r_state   <= S_TRAIN;
          r_tx_word <= TRAIN_WORD;
        end
      endcase
    end
  end

  assign tx_word    = r_tx_word;
  assign train_done = r_train_done;
  assign busy       = r_busy;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_lvds_tx_frame_gen.sv
// tb_lvds_tx_frame_gen
// Scoreboard bench for lvds_tx_frame_gen. Two instances are used:
//   dut1 keeps the default parameters and covers training, single and
//        held-start frames, retrain and reset.
//   dut2 uses short frames and covers the 8-bit sequence wrap.
// For every cycle, the expected word and flags are pushed when the inputs
// are driven (on the falling edge). They are popped and compared just
// after the next rising edge.

module tb_lvds_tx_frame_gen;

  localparam logic [9:0] TRAIN_W = 10'h3E0;
  localparam logic [9:0] IDLE_W  = 10'h0F8;

  typedef struct {
    logic [9:0]  word;
    logic        td;
    logic        bz;
    logic [15:0] fc;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst1, start1, retrain1;
  logic        rst2, start2, retrain2;
  logic [9:0]  tx_word1, tx_word2;
  logic        train_done1, train_done2;
  logic        busy1, busy2;
  logic [15:0] frame_cnt1, frame_cnt2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  int n_checks = 0;
  int n_errors = 0;
  int seq_m[2];
  int fc_m[2];

  lvds_tx_frame_gen dut1 (
    .sys_clk    (clk),
    .rst        (rst1),
    .start      (start1),
    .retrain    (retrain1),
    .tx_word    (tx_word1),
    .train_done (train_done1),
    .busy       (busy1),
    .frame_cnt  (frame_cnt1)
  );

  lvds_tx_frame_gen #(
    .TRAIN_WORDS (4),
    .PAYLOAD_LEN (4),
    .GAP_WORDS   (2)
  ) dut2 (
    .sys_clk    (clk),
    .rst        (rst2),
    .start      (start2),
    .retrain    (retrain2),
    .tx_word    (tx_word2),
    .train_done (train_done2),
    .busy       (busy2),
    .frame_cnt  (frame_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  // Compare each instance against its scoreboard just after the edge.
  always @(posedge clk) begin
    #1;
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      check({e1.tag, ".word"}, 32'(tx_word1),    32'(e1.word));
      check({e1.tag, ".td"},   32'(train_done1), 32'(e1.td));
      check({e1.tag, ".busy"}, 32'(busy1),       32'(e1.bz));
      check({e1.tag, ".fcnt"}, 32'(frame_cnt1),  32'(e1.fc));
    end
    if (q2.size() != 0) begin
      e2 = q2.pop_front();
      check({e2.tag, ".word"}, 32'(tx_word2),    32'(e2.word));
      check({e2.tag, ".td"},   32'(train_done2), 32'(e2.td));
      check({e2.tag, ".busy"}, 32'(busy2),       32'(e2.bz));
      check({e2.tag, ".fcnt"}, 32'(frame_cnt2),  32'(e2.fc));
    end
  end

  // Drive one cycle of inputs and record what must appear after the edge.
  task automatic step(input int d, input logic st, input logic rt, input logic rs,
                      input logic [9:0] w, input logic td, input logic bz,
                      input logic [15:0] fc, input string tag);
    exp_t e;
    @(negedge clk);
    if (d == 0) begin
      start1 = st; retrain1 = rt; rst1 = rs;
    end else begin
      start2 = st; retrain2 = rt; rst2 = rs;
    end
    e.word = w; e.td = td; e.bz = bz; e.fc = fc; e.tag = tag;
    if (d == 0) q1.push_back(e);
    else        q2.push_back(e);
  endtask

  // Training run. The first cycle may carry a retrain/start request.
  task automatic train_seq(input int d, input logic rt, input logic st, input string tag);
    int tw;
    tw = (d == 0) ? 256 : 4;
    for (int k = 0; k < tw; k++)
      step(d, (k == 0) ? st : 1'b0, (k == 0) ? rt : 1'b0, 1'b0,
           TRAIN_W, 1'b0, 1'b0, 16'd0, tag);
    step(d, 1'b0, 1'b0, 1'b0, IDLE_W, 1'b1, 1'b0, 16'd0, {tag, "_first_idle"});
    seq_m[d] = 0;
    fc_m[d]  = 0;
  endtask

  task automatic idles(input int d, input int n, input string tag);
    for (int k = 0; k < n; k++)
      step(d, 1'b0, 1'b0, 1'b0, IDLE_W, 1'b1, 1'b0, 16'(fc_m[d]), tag);
  endtask

  // One full frame starting from IDLE. 'hold' keeps start high throughout.
  task automatic frame(input int d, input logic hold, input string tag);
    int         p, g;
    logic [7:0] s, b, sum;
    p   = (d == 0) ? 125 : 4;
    g   = (d == 0) ? 16 : 2;
    s   = 8'(seq_m[d]);
    sum = 8'd0;
    step(d, 1'b1, 1'b0, 1'b0, {2'b10, s}, 1'b1, 1'b1, 16'(fc_m[d]), {tag, "_hdr"});
    for (int i = 0; i < p; i++) begin
      b   = s + 8'(i);
      sum = sum + b;
      step(d, hold, 1'b0, 1'b0, {2'b01, b}, 1'b1, 1'b1, 16'(fc_m[d]),
           $sformatf("%s_pay%0d", tag, i));
    end
    step(d, hold, 1'b0, 1'b0, {2'b11, sum}, 1'b1, 1'b1, 16'(fc_m[d]), {tag, "_csum"});
    seq_m[d] = (seq_m[d] + 1) % 256;
    fc_m[d]  = (fc_m[d] + 1) % 65536;
    for (int k = 0; k < g; k++)
      step(d, hold, 1'b0, 1'b0, IDLE_W, 1'b1, 1'b1, 16'(fc_m[d]), {tag, "_gap"});
    step(d, hold, 1'b0, 1'b0, IDLE_W, 1'b1, 1'b0, 16'(fc_m[d]), {tag, "_idle"});
  endtask

  initial begin
    rst1 = 1'b1; start1 = 1'b0; retrain1 = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; retrain2 = 1'b0;
    seq_m = '{0, 0};
    fc_m  = '{0, 0};

    // Reset values, then 256 training words and the first idle word.
    for (int k = 0; k < 3; k++)
      step(0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 16'd0, "reset");
    train_seq(0, 1'b0, 1'b0, "train");
    idles(0, 3, "idle");

    // A single frame from one start pulse. No second frame may follow.
    frame(0, 1'b0, "single");
    idles(0, 5, "after_single");

    // Retrain at payload byte 50: the frame is dropped without a checksum.
    step(0, 1'b1, 1'b0, 1'b0, {2'b10, 8'(seq_m[0])}, 1'b1, 1'b1, 16'(fc_m[0]), "rt_hdr");
    for (int i = 0; i <= 50; i++)
      step(0, 1'b0, 1'b0, 1'b0, {2'b01, 8'(seq_m[0] + i)}, 1'b1, 1'b1, 16'(fc_m[0]),
           $sformatf("rt_pay%0d", i));
    train_seq(0, 1'b1, 1'b0, "retrain_pay");
    idles(0, 2, "after_retrain");

    // Start held high: three back-to-back frames, headers 200..202.
    for (int f = 0; f < 3; f++)
      frame(0, 1'b1, $sformatf("held%0d", f));
    idles(0, 4, "after_held");

    // Retrain and start in the same IDLE cycle: retrain wins, no header.
    train_seq(0, 1'b1, 1'b1, "rt_and_start");
    idles(0, 4, "after_rt_start");

    // Reset in the middle of a frame.
    step(0, 1'b1, 1'b0, 1'b0, {2'b10, 8'(seq_m[0])}, 1'b1, 1'b1, 16'(fc_m[0]), "rst_hdr");
    for (int i = 0; i < 10; i++)
      step(0, 1'b0, 1'b0, 1'b0, {2'b01, 8'(seq_m[0] + i)}, 1'b1, 1'b1, 16'(fc_m[0]),
           $sformatf("rst_pay%0d", i));
    for (int k = 0; k < 2; k++)
      step(0, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 16'd0, "rst_mid");
    train_seq(0, 1'b0, 1'b0, "rst_train");
    frame(0, 1'b0, "after_rst");
    idles(0, 2, "end1");

    // Sequence wrap on the short-frame instance: 257 back-to-back frames.
    for (int k = 0; k < 2; k++)
      step(1, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 16'd0, "w_reset");
    train_seq(1, 1'b0, 1'b0, "w_train");
    for (int f = 0; f < 257; f++)
      frame(1, 1'b1, $sformatf("wrap%0d", f));
    idles(1, 3, "w_end");

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lvds_tx_frame_gen.md
# lvds_tx_frame_gen

Transmit-side word source for the LVDS link test: generates the 10-bit parallel words that the LVDS serializer shifts out on `data_txp`. After reset it emits a training pattern so the receiver's bit-slip aligner can lock. It then sends framed test packets: header, incrementing payload and checksum. The payload sequence is exactly what the receive-side repeat/increment checker expects, so the full loop (generator → serializer → receiver → aligner → checker) closes on one board.

## Interface

Parameters:
- `TRAIN_WORDS`, 256: number of training words sent after reset or retrain (≥1).
- `PAYLOAD_LEN`, 125: payload words per frame (1..255).
- `GAP_WORDS`, 16: idle words inserted after each frame (≥1).
- `TRAIN_WORD`, 10'h3E0: training/alignment word.
- `IDLE_WORD`, 10'h0F8: idle filler word.

Ports:
- `sys_clk` in 1: single clock, also the serializer's parallel `tx_inclock`.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request frame(s); level-sensitive, sampled only in IDLE.
- `retrain` in 1: single-cycle pulse; abort and resend training.
- `tx_word` out 10: parallel word to the serializer, registered, one per cycle.
- `train_done` out 1: high once training completes; low during TRAIN.
- `busy` out 1: high in HDR/PAY/CSUM/GAP.
- `frame_cnt` out 16: completed frames since reset or retrain; wraps at 16'hFFFF→0.

## Operation

- Word formats:
  - header = {2'b10, seq[7:0]}.
  - payload = {2'b01, byte}.
  - checksum = {2'b11, sum[7:0]}.
- States: TRAIN → IDLE → HDR → PAY → CSUM → GAP → IDLE.
- TRAIN:
  - Output TRAIN_WORD for exactly TRAIN_WORDS cycles, then go to IDLE.
  - `train_done` goes to 1 in the same cycle the first IDLE word appears.
- IDLE: output IDLE_WORD. If `start`=1, go to HDR.
- HDR: one cycle, header with current 8-bit `seq`.
- PAY: PAYLOAD_LEN cycles. Byte i (i = 0..PAYLOAD_LEN-1) = (seq + i) mod 256, with 8-bit wrap.
- CSUM: one cycle. `sum` = 8-bit modulo-256 sum of all payload bytes of this frame, accumulated during PAY.
- GAP:
  - Output IDLE_WORD for GAP_WORDS cycles, then go to IDLE.
  - On GAP entry: `seq` += 1 (8-bit wrap) and `frame_cnt` += 1.
- `start` held high gives back-to-back frames separated by GAP_WORDS + 1 idle words (GAP plus one IDLE cycle).
- `start` is ignored outside IDLE; no queuing.
- `retrain` in any state:
  - Next cycle enters TRAIN with a fresh training count.
  - Clears `train_done`, `busy`, `seq` and `frame_cnt`.
  - An aborted frame is not counted and has no checksum.
- `retrain` and `start` in the same cycle: `retrain` wins.
- `rst` has priority over everything.

## Timing

- Reset values:
  - `tx_word`=10'h000, `train_done`=0, `busy`=0, `frame_cnt`=0.
  - Internal state: `seq`=0, state=TRAIN, counters=0.
- The first cycle after `rst` deasserts shows TRAIN_WORD on `tx_word`.
- Training: TRAIN_WORD on cycles 1..TRAIN_WORDS after reset release. IDLE_WORD and `train_done`=1 appear on cycle TRAIN_WORDS+1.
- Start latency: `start` sampled high in IDLE on cycle n gives the header on cycle n+1 and `busy`=1 on cycle n+1.
- Frame length: 1 + PAYLOAD_LEN + 1 words. The checksum appears on cycle n+PAYLOAD_LEN+2.
- GAP: `frame_cnt` updates on the first GAP cycle, cycle n+PAYLOAD_LEN+3. `busy` drops on the first IDLE cycle after GAP.
- Retrain: `retrain` on cycle m gives TRAIN_WORD on cycle m+1, `train_done`=0 on cycle m+1, and IDLE on cycle m+TRAIN_WORDS+1.
- Counter widths:
  - Training counter is ≥ clog2(TRAIN_WORDS+1) bits.
  - Payload and gap counters are 8 bits.
  - Checksum accumulator is 8 bits, wraps silently.

## Test plan

- Reset release, defaults: exactly 256 words of 10'h3E0. Then 10'h0F8 with `train_done`=1 on cycle 257. `busy`=0, `frame_cnt`=0 throughout.
- Single frame, `start` pulsed once in IDLE:
  - Header 10'h200 (seq 0).
  - Payload 10'h100..10'h17C (bytes 0..124).
  - Checksum 10'h346 (sum 7750 mod 256 = 0x46).
  - Then 16 words of 10'h0F8; `frame_cnt`=1.
- `start` held high for 3 frames:
  - Headers 10'h200, 10'h201, 10'h202.
  - Second payload starts at byte 1 and ends at byte 125 (10'h17D).
  - Each inter-frame gap is exactly 17 IDLE_WORD cycles; `frame_cnt`=3.
- Seq wrap:
  - Run 256 frames with PAYLOAD_LEN=4; frame 256 header is 10'h2FF, payload bytes FF, 00, 01, 02, checksum 10'h302.
  - Next frame header is 10'h200; `frame_cnt`=256.
- `retrain` at payload byte 50:
  - Next cycle TRAIN_WORD for 256 cycles; `frame_cnt`=0, `train_done`=0, no checksum emitted.
  - Next frame header is 10'h200.
- `retrain` and `start` in the same IDLE cycle: TRAIN is entered and no header appears. `rst` asserted mid-frame: next cycle `tx_word`=10'h000, all outputs at reset values.
